control_fsm32: RTL

Multi-cycle control unit for the 32-bit MIPS-subset core. It replaces single-cycle decode with a five-state sequencer (IF, ID, EX, MEM, WB) and configurable fetch and data-memory wait states. It emits one-cycle write strobes per phase plus datapath selects, which are latched per instruction. It sits between the instruction register and the datapath, and drives the PC, IR, register-file and data-memory write enables.

---
 rtl/ctrl_pkg.sv | 56 +++++
 rtl/instr_decode.sv | 57 +++++
 rtl/control_fsm32.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcode/funct constants and the select bundle
// shared by the control_fsm32 sequencer and its instruction decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [2:0] OP_IFMT  = 3'b001;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;

    typedef struct packed {
        logic       jr;
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       branch;
        logic       nbranch;
        logic       jmp;
        logic       jal;
        logic       i_format;
        logic       sftmd;
        logic [1:0] aluop;
        logic       lw;
        logic       sw;
    } sel_t;

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL)  || (fn == FN_SRL)  || (fn == FN_SRA) ||
               (fn == FN_SLLV) || (fn == FN_SRLV) || (fn == FN_SRAV);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational decode of Opcode/funct into the datapath
// select bundle and the illegal-opcode flag.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output sel_t       sel_o,
    output logic       illegal_o
);

    logic r_type;
    logic i_fmt;
    logic lw;
    logic sw;
    logic jmp;
    logic jal;
    logic beq;
    logic bne;

    always_comb begin
        r_type = (opcode_i == OP_RTYPE);
        i_fmt  = (opcode_i[5:3] == OP_IFMT);
        lw     = (opcode_i == OP_LW);
        sw     = (opcode_i == OP_SW);
        jmp    = (opcode_i == OP_J);
        jal    = (opcode_i == OP_JAL);
        beq    = (opcode_i == OP_BEQ);
        bne    = (opcode_i == OP_BNE);
    end

    always_comb begin
        sel_o          = '0;
        sel_o.jr       = r_type && (funct_i == FN_JR);
        sel_o.regdst   = r_type;
        sel_o.alusrc   = i_fmt | lw | sw;
        sel_o.memtoreg = lw;
        sel_o.branch   = beq;
        sel_o.nbranch  = bne;
        sel_o.jmp      = jmp;
        sel_o.jal      = jal;
        sel_o.i_format = i_fmt;
        sel_o.sftmd    = r_type && is_shift(funct_i);
        sel_o.lw       = lw;
        sel_o.sw       = sw;
        // R/I and branch classes are mutually exclusive, so this is {R|I, B|nB}
        if (r_type || i_fmt) begin
            sel_o.aluop = ALUOP_RI;
        end else if (beq || bne) begin
            sel_o.aluop = ALUOP_BR;
        end else begin
            sel_o.aluop = ALUOP_MEM;
        end
        illegal_o = ~(r_type | i_fmt | lw | sw | jmp | jal | beq | bne);
    end

endmodule

// File: rtl/control_fsm32.sv
// control_fsm32: multi-cycle IF/ID/EX/MEM/WB sequencer with fetch/memory waits.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes instead of NOP-ing them.
module control_fsm32
    import ctrl_pkg::*;
#(
    parameter int unsigned IF_WAIT  = 0,
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       stall,
    input  logic [5:0] Opcode,
    input  logic [5:0] Function_opcode,
    input  logic       Zero,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       BranchTaken,
    output logic       Jr,
    output logic       RegDST,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       Branch,
    output logic       nBranch,
    output logic       Jmp,
    output logic       Jal,
    output logic       I_format,
    output logic       Sftmd,
    output logic [1:0] ALUOp,
    output logic       Illegal,
    output logic [2:0] State
);

    localparam logic [3:0] IF_W  = 4'(IF_WAIT);
    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    state_e     state_q;
    state_e     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    sel_t       sel_q;
    sel_t       sel_d;
    sel_t       dec_sel;
    logic       dec_ill;
    logic       cnt_zero;
    logic       go;
    logic       pc_last;

    instr_decode u_dec (
        .opcode_i  (Opcode),
        .funct_i   (Function_opcode),
        .sel_o     (dec_sel),
        .illegal_o (dec_ill)
    );

    assign cnt_zero = (cnt_q == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IF;
            cnt_q   <= IF_W;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (!stall) begin
            unique case (state_q)
                ST_IF: begin
                    if (cnt_zero) state_d = ST_ID;
                    else          cnt_d   = cnt_q - 4'd1;
                end
                ST_ID: begin
                    sel_d = dec_sel;
                    if (dec_ill) begin
                        state_d = TRAP ? ST_HALT : ST_IF;
                    end else if (dec_sel.jmp || dec_sel.jr) begin
                        state_d = ST_IF;
                    end else if (dec_sel.jal) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_EX;
                    end
                end
                ST_EX: begin
                    if (sel_q.branch || sel_q.nbranch) state_d = ST_IF;
                    else if (sel_q.lw || sel_q.sw)     state_d = ST_MEM;
                    else                               state_d = ST_WB;
                end
                ST_MEM: begin
                    if (!cnt_zero)     cnt_d   = cnt_q - 4'd1;
                    else if (sel_q.sw) state_d = ST_IF;
                    else               state_d = ST_WB;
                end
                ST_WB:   state_d = ST_IF;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IF;
            endcase
            // wait counter reloads only on entry, so a stalled phase resumes
            if (state_d != state_q) begin
                if (state_d == ST_IF)       cnt_d = IF_W;
                else if (state_d == ST_MEM) cnt_d = MEM_W;
            end
        end
    end

    always_comb begin
        pc_last = 1'b0;
        unique case (state_q)
            ST_ID:   pc_last = dec_sel.jmp | dec_sel.jr | (dec_ill & ~TRAP);
            ST_EX:   pc_last = sel_q.branch | sel_q.nbranch;
            ST_MEM:  pc_last = cnt_zero & sel_q.sw;
            ST_WB:   pc_last = 1'b1;
            default: pc_last = 1'b0;
        endcase
    end

    assign go = ~reset & ~stall;

    assign IRWrite     = go & (state_q == ST_IF) & cnt_zero;
    assign PCWrite     = go & pc_last;
    assign RegWrite    = go & (state_q == ST_WB);
    assign MemRead     = go & (state_q == ST_MEM) & sel_q.lw;
    assign MemWrite    = go & (state_q == ST_MEM) & sel_q.sw;
    assign BranchTaken = go & (state_q == ST_EX) &
                         ((sel_q.branch & Zero) | (sel_q.nbranch & ~Zero));

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign Illegal = ~reset &
                     (((state_q == ST_ID) & dec_ill) | (state_q == ST_HALT));
`else
    assign Illegal = ~reset & (state_q == ST_ID) & dec_ill;
`endif

    assign Jr       = sel_q.jr;
    assign RegDST   = sel_q.regdst;
    assign ALUSrc   = sel_q.alusrc;
    assign MemtoReg = sel_q.memtoreg;
    assign Branch   = sel_q.branch;
    assign nBranch  = sel_q.nbranch;
    assign Jmp      = sel_q.jmp;
    assign Jal      = sel_q.jal;
    assign I_format = sel_q.i_format;
    assign Sftmd    = sel_q.sftmd;
    assign ALUOp    = sel_q.aluop;
    assign State    = state_q;

endmodule
